// File: rtl/lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_bridge
// Description : Converts single-cycle MAR/MDR requests into held memory
//               strobes, waits for mem_resp and returns read data. It also
//               generates the byte lanes for LDB/STB.
//               Optional response timeout: define LC3B_MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_bridge #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_read,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       mem_byte_enable,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_timeout;
    logic             w_waiting;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic [1:0]       r_be;
    logic             r_byte;

    assign w_waiting = (r_state == S_READ) || (r_state == S_WRITE);

`ifdef LC3B_MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_err;

    assign w_timeout = w_waiting && !mem_resp &&
                       (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt <= 8'd0;
            end else if (w_waiting && !mem_resp) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Error flag lives only for the DONE cycle that follows a timeout
            if (w_waiting) begin
                r_err <= w_timeout;
            end else begin
                r_err <= 1'b0;
            end
        end
    end

    assign resp_err = (r_state == S_DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_read) begin
                    w_next   = S_READ;
                    w_accept = 1'b1;
                end else if (req_write) begin
                    w_next   = S_WRITE;
                    w_accept = 1'b1;
                end
            end
            S_READ, S_WRITE: begin
                if (mem_resp || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= 2'b11;
            r_byte  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_byte <= req_byte;
                if (req_byte) begin
                    // Store byte goes out on both lanes; the enable picks one
                    r_be    <= req_addr[0] ? 2'b10 : 2'b01;
                    r_wdata <= {req_wdata[7:0], req_wdata[7:0]};
                end else begin
                    r_be    <= 2'b11;
                    r_wdata <= req_wdata;
                end
            end
            if ((r_state == S_READ) && mem_resp) begin
                if (r_byte) begin
                    r_rdata <= r_addr[0] ? {8'h00, mem_rdata[15:8]}
                                         : {8'h00, mem_rdata[7:0]};
                end else begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign resp_valid      = (r_state == S_DONE);
    assign mem_read        = (r_state == S_READ);
    assign mem_write       = (r_state == S_WRITE);
    assign resp_rdata      = r_rdata;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_be;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_mem_bridge
// Description : Directed self-checking bench for lc3b_mem_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_mem_bridge #(
        .WIDTH          (16),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_byte        (req_byte),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .busy            (busy),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_read  = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        clear_req();
        repeat (3) step();

        check_eq("rst_busy",  busy, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_err",   resp_err, 0);
        check_eq("rst_rd",    mem_read, 0);
        check_eq("rst_wr",    mem_write, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_addr",  mem_address, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_be",    mem_byte_enable, 2'b11);
        reset = 1'b0;
        step();

        // Word read with four-cycle memory latency
        req_read = 1'b1; req_addr = 16'h3000;
        step();
        clear_req();
        check_eq("t1_busy", busy, 1);
        check_eq("t1_wr",   mem_write, 0);
        check_eq("t1_addr", mem_address, 16'h3000);
        check_eq("t1_be",   mem_byte_enable, 2'b11);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_rd_hold", mem_read, 1);
            check_eq("t1_no_valid", resp_valid, 0);
            if (i == 3) begin
                mem_resp = 1'b1; mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_resp = 1'b0; mem_rdata = 16'h0000;
        check_eq("t1_valid", resp_valid, 1);
        check_eq("t1_rd_drop", mem_read, 0);
        check_eq("t1_rdata", resp_rdata, 16'hBEEF);
        check_eq("t1_err", resp_err, 0);
        check_eq("t1_busy_done", busy, 1);
        step();
        check_eq("t1_pulse", resp_valid, 0);
        check_eq("t1_idle", busy, 0);
        check_eq("t1_rdata_hold", resp_rdata, 16'hBEEF);

        // Byte read, high lane, minimum latency
        req_read = 1'b1; req_byte = 1'b1; req_addr = 16'h3001;
        step();
        clear_req();
        check_eq("t2h_be",   mem_byte_enable, 2'b10);
        check_eq("t2h_addr", mem_address, 16'h3001);
        mem_resp = 1'b1; mem_rdata = 16'hA55A;
        step();
        mem_resp = 1'b0;
        check_eq("t2h_valid", resp_valid, 1);
        check_eq("t2h_rdata", resp_rdata, 16'h00A5);
        step();

        // Byte read, low lane
        req_read = 1'b1; req_byte = 1'b1; req_addr = 16'h3002;
        step();
        clear_req();
        check_eq("t2l_be", mem_byte_enable, 2'b01);
        mem_resp = 1'b1; mem_rdata = 16'hA55A;
        step();
        mem_resp = 1'b0;
        check_eq("t2l_rdata", resp_rdata, 16'h005A);
        step();

        // Byte write, high lane, data replicated
        req_write = 1'b1; req_byte = 1'b1; req_addr = 16'h4001; req_wdata = 16'h1234;
        step();
        clear_req();
        check_eq("t3_wr",    mem_write, 1);
        check_eq("t3_rd",    mem_read, 0);
        check_eq("t3_wdata", mem_wdata, 16'h3434);
        check_eq("t3_be",    mem_byte_enable, 2'b10);
        check_eq("t3_addr",  mem_address, 16'h4001);
        step();
        step();
        check_eq("t3_wr_hold",    mem_write, 1);
        check_eq("t3_wdata_hold", mem_wdata, 16'h3434);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check_eq("t3_valid",  resp_valid, 1);
        check_eq("t3_wr_drop", mem_write, 0);
        check_eq("t3_rdata_keep", resp_rdata, 16'h005A);
        step();

        // Word write to an odd address passes through unaligned
        req_write = 1'b1; req_addr = 16'h4001; req_wdata = 16'h1234;
        step();
        clear_req();
        check_eq("t3w_wdata", mem_wdata, 16'h1234);
        check_eq("t3w_be",    mem_byte_enable, 2'b11);
        check_eq("t3w_addr",  mem_address, 16'h4001);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check_eq("t3w_valid", resp_valid, 1);
        step();

        // Read wins over write; resp on accept edge and busy-time requests ignored
        req_read = 1'b1; req_write = 1'b1; req_addr = 16'h5000; req_wdata = 16'hFFFF;
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        clear_req();
        req_write = 1'b1; req_addr = 16'h6000;
        check_eq("t4_rd",    mem_read, 1);
        check_eq("t4_wr",    mem_write, 0);
        check_eq("t4_busy",  busy, 1);
        check_eq("t4_wdata", mem_wdata, 16'hFFFF);
        step();
        clear_req();
        check_eq("t4_rd_hold",  mem_read, 1);
        check_eq("t4_addr",     mem_address, 16'h5000);
        check_eq("t4_no_valid", resp_valid, 0);
        check_eq("t4_busy2",    busy, 1);
        mem_resp = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_resp = 1'b0;
        check_eq("t4_valid", resp_valid, 1);
        check_eq("t4_rdata", resp_rdata, 16'h1111);
        check_eq("t4_busy3", busy, 1);
        req_read = 1'b1; req_addr = 16'h0200;
        step();
        check_eq("t4_done_ignored", busy, 0);
        check_eq("t4_no_queue", mem_write, 0);
        step();
        clear_req();
        check_eq("t4_b2b_rd",   mem_read, 1);
        check_eq("t4_b2b_addr", mem_address, 16'h0200);
        mem_resp = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_resp = 1'b0;
        check_eq("t4_b2b_rdata", resp_rdata, 16'h2222);
        step();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check_eq("idle_resp_busy",  busy, 0);
        check_eq("idle_resp_valid", resp_valid, 0);
        step();
        check_eq("idle_resp_valid2", resp_valid, 0);

`ifdef LC3B_MEM_TIMEOUT_EN
        // No response: strobe held for TIMEOUT_CYCLES then error completion
        req_read = 1'b1; req_addr = 16'h7000;
        step();
        clear_req();
        n = 0;
        while (mem_read && n < 20) begin
            n++;
            step();
        end
        check_eq("t6_cycles", n, 8);
        check_eq("t6_valid",  resp_valid, 1);
        check_eq("t6_err",    resp_err, 1);
        check_eq("t6_rdata",  resp_rdata, 16'h2222);
        step();
        check_eq("t6_valid_pulse", resp_valid, 0);
        check_eq("t6_err_pulse",   resp_err, 0);
        check_eq("t6_idle",        busy, 0);
`else
        // No response: waits indefinitely, no error; reset recovers
        req_read = 1'b1; req_addr = 16'h7000;
        step();
        clear_req();
        n = 0;
        repeat (30) begin
            if (resp_valid) n++;
            step();
        end
        check_eq("t6_no_valid", n, 0);
        check_eq("t6_rd_hold",  mem_read, 1);
        check_eq("t6_busy",     busy, 1);
        check_eq("t6_err",      resp_err, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_recover", busy, 0);
`endif

        // Reset two cycles into a read
        req_read = 1'b1; req_addr = 16'h3000;
        step();
        clear_req();
        step();
        check_eq("t5_rd", mem_read, 1);
        reset = 1'b1;
        step();
        check_eq("t5_rd_drop", mem_read, 0);
        check_eq("t5_busy",    busy, 0);
        check_eq("t5_valid",   resp_valid, 0);
        check_eq("t5_addr",    mem_address, 0);
        check_eq("t5_be",      mem_byte_enable, 2'b11);
        reset = 1'b0;
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        check_eq("t5_valid2", resp_valid, 0);
        check_eq("t5_busy2",  busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
